// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            flush_i,
  output logic            ready_o,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] div_data_o,
  output logic [XLEN-1:0] rem_data_o
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            r_state;
  logic [CntW-1:0]   r_cnt;
  logic              r_word;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_dvs;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quot;
  logic              r_valid;
  logic [XLEN-1:0]   r_div_data;
  logic [XLEN-1:0]   r_rem_data;

  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_b;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_mag_a;
  logic [XLEN-1:0]   w_mag_b;
  logic [XLEN-1:0]   w_min;
  logic              w_div0;
  logic              w_ovf;
  logic [XLEN-1:0]   w_low;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_nx;
  logic [XLEN-1:0]   w_quot_nx;
  logic [XLEN-1:0]   w_q_fix;
  logic [XLEN-1:0]   w_r_fix;
  logic              w_last;

  function automatic logic [XLEN-1:0] fix_w(input logic word, input logic [XLEN-1:0] x);
    return word ? {{(XLEN-32){x[31]}}, x[31:0]} : x;
  endfunction

  // Operand preprocessing: W truncation/extension, then magnitudes. The most-negative
  // value negates to itself, which read as unsigned is exactly its magnitude.
  always_comb begin
    w_a = dividend_i;
    w_b = divisor_i;
    if (word_i) begin
      w_a = signed_i ? {{(XLEN-32){dividend_i[31]}}, dividend_i[31:0]}
                     : {{(XLEN-32){1'b0}}, dividend_i[31:0]};
      w_b = signed_i ? {{(XLEN-32){divisor_i[31]}}, divisor_i[31:0]}
                     : {{(XLEN-32){1'b0}}, divisor_i[31:0]};
    end
    w_sa    = signed_i & w_a[XLEN-1];
    w_sb    = signed_i & w_b[XLEN-1];
    w_mag_a = w_sa ? (~w_a + 1'b1) : w_a;
    w_mag_b = w_sb ? (~w_b + 1'b1) : w_b;
    w_min   = word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    w_div0  = (w_b == '0);
    w_ovf   = signed_i & (w_a == w_min) & (&w_b);
  end

  // Restoring step. The shifted partial remainder may carry into bit XLEN; when it does it
  // is necessarily >= the divisor and the wrapped XLEN-bit difference is still exact.
  always_comb begin
    w_low     = {r_rem[XLEN-2:0], r_quot[XLEN-1]};
    w_ge      = r_rem[XLEN-1] | (w_low >= r_dvs);
    w_rem_nx  = w_ge ? (w_low - r_dvs) : w_low;
    w_quot_nx = {r_quot[XLEN-2:0], w_ge};
    w_q_fix   = r_neg_q ? (~w_quot_nx + 1'b1) : w_quot_nx;
    w_r_fix   = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    w_last    = (r_cnt == (r_word ? CntW'(31) : CntW'(XLEN - 1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_word     <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dvs      <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_valid    <= 1'b0;
      r_div_data <= '0;
      r_rem_data <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start_i && !flush_i) begin
            r_word  <= word_i;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_dvs   <= w_mag_b;
            r_cnt   <= '0;
            r_rem   <= '0;
            if (w_div0) begin
              r_div_data <= '1;
              r_rem_data <= fix_w(word_i, w_a);
              r_valid    <= 1'b1;
              r_state    <= StDone;
            end else if (w_ovf) begin
              r_div_data <= w_a;
              r_rem_data <= '0;
              r_valid    <= 1'b1;
              r_state    <= StDone;
            end else begin
              // W ops start with the 32-bit magnitude in the top half so 32 shifts suffice.
              r_quot  <= word_i ? {w_mag_a[31:0], {(XLEN-32){1'b0}}} : w_mag_a;
              r_state <= StCalc;
            end
          end
        end
        StCalc: begin
          if (flush_i) begin
            r_state <= StIdle;
          end else begin
            r_rem  <= w_rem_nx;
            r_quot <= w_quot_nx;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
              r_div_data <= fix_w(r_word, w_q_fix);
              r_rem_data <= fix_w(r_word, w_r_fix);
              r_valid    <= 1'b1;
              r_state    <= StDone;
            end
          end
        end
        StDone: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready_o    = (r_state == StIdle);
  assign busy_o     = (r_state != StIdle);
  // A flush in the DONE cycle still kills the result.
  assign valid_o    = r_valid & ~flush_i;
  assign div_data_o = r_div_data;
  assign rem_data_o = r_rem_data;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: reset, latency, arithmetic vectors, flush and mid-op reset.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic        word_i;
  logic [63:0] dividend_i;
  logic [63:0] divisor_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        valid_o;
  logic [63:0] div_data_o;
  logic [63:0] rem_data_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        s;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic [7:0]  lat;
  } vec_t;

  div_unit #(.XLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .word_i    (word_i),
    .dividend_i(dividend_i),
    .divisor_i (divisor_i),
    .flush_i   (flush_i),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .valid_o   (valid_o),
    .div_data_o(div_data_o),
    .rem_data_o(rem_data_o)
  );

  always #5 clk = ~clk;

  // Called at a negedge (cycle 0): asserts start, then waits up to 150 cycles for valid_o.
  task automatic run_op(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output logic [63:0] q, output logic [63:0] r,
                        output int nobusy);
    lat = -1; q = '0; r = '0; nobusy = 0;
    signed_i = s; word_i = w; dividend_i = a; divisor_i = b; start_i = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (!busy_o) nobusy++;
      if (valid_o) begin
        lat = c; q = div_data_o; r = rem_data_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    total++; if (div_data_o !== 64'd0) begin bad++; $display("FAIL reset_q got=%h exp=0", div_data_o); end
    total++; if (rem_data_o !== 64'd0) begin bad++; $display("FAIL reset_r got=%h exp=0", rem_data_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat, nobusy;
    logic [63:0] q, r;
    run_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, nobusy);
    total++; if (lat !== 65) begin bad++; $display("FAIL divu_lat got=%0d exp=65", lat); end
    total++; if (nobusy !== 0) begin bad++; $display("FAIL divu_busy idle_cycles=%0d exp=0", nobusy); end
    total++; if (q !== 64'd14) begin bad++; $display("FAIL divu_q got=%h exp=%h", q, 64'd14); end
    total++; if (r !== 64'd2) begin bad++; $display("FAIL divu_r got=%h exp=%h", r, 64'd2); end
    @(negedge clk);
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL divu_ready66 got=%b exp=1", ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL divu_valid66 got=%b exp=0", valid_o); end
    total++; if (div_data_o !== 64'd14) begin bad++; $display("FAIL divu_hold got=%h exp=%h", div_data_o, 64'd14); end
  endtask

  task automatic test_arith();
    vec_t v[$];
    int lat, nobusy;
    logic [63:0] q, r;
    v.push_back({1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD,
                 64'hFFFF_FFFF_FFFF_FFFF, 8'd65});
    v.push_back({1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 8'd65});
    v.push_back({1'b0, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 8'd1});
    v.push_back({1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_FFFF_FFFB, 8'd1});
    v.push_back({1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'h8000_0000_0000_0000, 64'd0, 8'd1});
    v.push_back({1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'hFFFF_FFFF_8000_0000, 64'd0, 8'd1});
    v.push_back({1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 8'd33});
    v.push_back({1'b0, 1'b1, 64'hFFFF_FFFF_0000_0005, 64'd3, 64'd1, 64'd2, 8'd33});
    v.push_back({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd65});
    v.push_back({1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 8'd65});
    v.push_back({1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
                 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 8'd33});
    v.push_back({1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 8'd65});
    v.push_back({1'b0, 1'b1, 64'h0000_0005_0000_0007, 64'h0000_0009_0000_0000,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 8'd1});
    v.push_back({1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 8'd65});
    v.push_back({1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14,
                 64'hFFFF_FFFF_FFFF_FFFE, 8'd65});
    v.push_back({1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF, 64'hF, 8'd33});
    foreach (v[i]) begin
      // One negedge after valid_o: the earliest cycle a new start is accepted.
      @(negedge clk);
      run_op(v[i].s, v[i].w, v[i].a, v[i].b, lat, q, r, nobusy);
      total++; if (lat !== int'(v[i].lat)) begin
        bad++; $display("FAIL vec%0d_lat got=%0d exp=%0d", i, lat, v[i].lat);
      end
      total++; if (nobusy !== 0) begin
        bad++; $display("FAIL vec%0d_busy idle_cycles=%0d exp=0", i, nobusy);
      end
      total++; if (q !== v[i].q) begin bad++; $display("FAIL vec%0d_q got=%h exp=%h", i, q, v[i].q); end
      total++; if (r !== v[i].r) begin bad++; $display("FAIL vec%0d_r got=%h exp=%h", i, r, v[i].r); end
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lat, nobusy, seen;
    logic [63:0] q, r;
    seen = 0;
    signed_i = 1'b0; word_i = 1'b0; dividend_i = 64'd1000; divisor_i = 64'd3; start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (valid_o) seen++;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", ready_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", valid_o); end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_early_valid got=%0d exp=0", seen); end
    run_op(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, nobusy);
    total++; if (lat !== 65) begin bad++; $display("FAIL flush_next_lat got=%0d exp=65", lat); end
    total++; if (q !== 64'd14) begin bad++; $display("FAIL flush_next_q got=%h exp=%h", q, 64'd14); end
    total++; if (r !== 64'd2) begin bad++; $display("FAIL flush_next_r got=%h exp=%h", r, 64'd2); end
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    signed_i = 1'b0; word_i = 1'b0; dividend_i = 64'd500; divisor_i = 64'd9; start_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rst_mid_busy20 got=%b exp=1", busy_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", ready_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy_o); end
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", valid_o); end
    total++; if (div_data_o !== 64'd0) begin bad++; $display("FAIL rst_mid_q got=%h exp=0", div_data_o); end
    total++; if (rem_data_o !== 64'd0) begin bad++; $display("FAIL rst_mid_r got=%h exp=0", rem_data_o); end
    // No stale completion may appear after the reset.
    repeat (70) begin
      @(negedge clk);
      total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_mid_late_valid got=%b exp=0", valid_o); end
    end
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; word_i = 1'b0; flush_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    test_reset();
    test_divu_basic();
    test_arith();
    test_flush();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
